// File: rtl/siren_note_sequencer.sv
// siren_note_sequencer: steps through a fixed 16-entry note table and drives a
// square-wave tone generator with a 20-bit half-period reload (DIVIDER) and a
// sound enable (GATE).
// Optional build macro SIREN_TEMPO_EN adds a TEMPO[1:0] input that divides the
// duration tick length by 2^TEMPO, sampled once per note.
module siren_note_sequencer #(
  parameter int unsigned TICK_CYCLES = 2000000,
  parameter int unsigned GAP_CYCLES  = 160000,
  parameter int unsigned NUM_NOTES   = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        STOP,
  input  logic        LOOP,
`ifdef SIREN_TEMPO_EN
  input  logic [1:0]  TEMPO,
`endif
  output logic [19:0] DIVIDER,
  output logic        GATE,
  output logic        NOTE_STB,
  output logic [3:0]  NOTE_IDX,
  output logic        BUSY
);

  localparam int unsigned CW = 21;
  localparam logic [CW-1:0] TICK_W   = CW'(TICK_CYCLES);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX = 4'(NUM_NOTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NOTE, S_GAP} state_e;

  // Table entry {dur[2:0], oct[2:0], semi[3:0]}; semi 12..15 is a rest.
  function automatic logic [9:0] note_entry(input logic [3:0] idx);
    if (idx == 4'd15) begin
      return {3'd7, 3'd0, 4'd12};
    end else if (idx[0] == 1'b0) begin
      return {3'd3, 3'd4, 4'd9};
    end else begin
      return {3'd3, 3'd5, 4'd4};
    end
  endfunction

  // Octave-0 half-period in 16 MHz cycles, round(8e6 / f).
  function automatic logic [19:0] base_half_period(input logic [3:0] semi);
    case (semi)
      4'd0:    return 20'd489237;
      4'd1:    return 20'd461787;
      4'd2:    return 20'd435872;
      4'd3:    return 20'd411417;
      4'd4:    return 20'd388312;
      4'd5:    return 20'd366518;
      4'd6:    return 20'd345946;
      4'd7:    return 20'd326531;
      4'd8:    return 20'd308202;
      4'd9:    return 20'd290909;
      4'd10:   return 20'd274584;
      4'd11:   return 20'd259168;
      default: return 20'd0;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [19:0]   div_q, div_d;
  logic          gate_q, gate_d;
  logic          stb_q, stb_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    tick_q, tick_d;
  logic [2:0]    dur_q, dur_d;
  logic [CW-1:0] tlen_q, tlen_d;

  logic [9:0]    entry;
  logic [2:0]    ent_dur;
  logic [2:0]    ent_oct;
  logic [3:0]    ent_semi;
  logic [19:0]   pitch;
  logic [CW-1:0] tick_sel;

  // Decode the current table entry and derive its divider and tick length.
  always_comb begin
    entry    = note_entry(idx_q);
    ent_dur  = entry[9:7];
    ent_oct  = entry[6:4];
    ent_semi = entry[3:0];
    pitch    = (base_half_period(ent_semi) >> ent_oct) - 20'd1;
`ifdef SIREN_TEMPO_EN
    tick_sel = TICK_W >> TEMPO;
    // A tick shorter than one cycle cannot be counted; clamp to one.
    if (tick_sel == '0) begin
      tick_sel = CW'(1);
    end
`else
    tick_sel = TICK_W;
`endif
  end

  // Next-state and registered-output logic; STOP overrides every state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
    gate_d  = gate_q;
    stb_d   = 1'b0;
    busy_d  = busy_q;
    cyc_d   = cyc_q;
    tick_d  = tick_q;
    dur_d   = dur_q;
    tlen_d  = tlen_q;
    if (STOP) begin
      state_d = S_IDLE;
      gate_d  = 1'b0;
      busy_d  = 1'b0;
      idx_d   = '0;
      cyc_d   = '0;
      tick_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_d = S_LOAD;
            idx_d   = '0;
            busy_d  = 1'b1;
          end
        end
        S_LOAD: begin
          state_d = S_NOTE;
          stb_d   = 1'b1;
          cyc_d   = '0;
          tick_d  = '0;
          dur_d   = ent_dur;
          tlen_d  = tick_sel;
          if (ent_semi >= 4'd12) begin
            gate_d = 1'b0;
          end else begin
            gate_d = 1'b1;
            div_d  = pitch;
          end
        end
        S_NOTE: begin
          if (cyc_q == tlen_q - CW'(1)) begin
            cyc_d = '0;
            if (tick_q == dur_q) begin
              state_d = S_GAP;
              gate_d  = 1'b0;
            end else begin
              tick_d = tick_q + 3'd1;
            end
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end
        S_GAP: begin
          if (cyc_q == GAP_LAST) begin
            cyc_d = '0;
            if (idx_q < LAST_IDX) begin
              idx_d   = idx_q + 4'd1;
              state_d = S_LOAD;
            end else if (LOOP) begin
              idx_d   = '0;
              state_d = S_LOAD;
            end else begin
              idx_d   = '0;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, counter and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      div_q   <= '0;
      gate_q  <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      cyc_q   <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
      tlen_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      gate_q  <= gate_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      cyc_q   <= cyc_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
      tlen_q  <= tlen_d;
    end
  end

  assign DIVIDER  = div_q;
  assign GATE     = gate_q;
  assign NOTE_STB = stb_q;
  assign NOTE_IDX = idx_q;
  assign BUSY     = busy_q;

endmodule
